// File: rtl/rsp_tone_stepper.sv
// Staircase-sine stimulus source for adrv9009_rsp: three free-running 8-step tone generators
// and a segment sequencer that plays a zero lead-in, then tone 0, tone 1 and tone 2.
module rsp_tone_stepper #(
    parameter int DW    = 16,
    parameter int CW    = 6,
    parameter int SCW   = 13,
    parameter int A_MID = 23170,
    parameter int A_HI  = 32767,
    parameter int A_LO  = -32768
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [CW-1:0]        hold0,
    input  logic [CW-1:0]        hold1,
    input  logic [CW-1:0]        hold2,
    input  logic [SCW-1:0]       lead_in,
    input  logic [SCW-1:0]       seg_end0,
    input  logic [SCW-1:0]       seg_end1,
    output logic signed [DW-1:0] out,
    output logic                 out_valid,
    output logic [1:0]           tone_idx
);

    localparam logic signed [DW-1:0] LV_MID = DW'(A_MID);
    localparam logic signed [DW-1:0] LV_HI  = DW'(A_HI);
    localparam logic signed [DW-1:0] LV_LO  = DW'(A_LO);
    localparam logic signed [DW-1:0] LV_NMID = -LV_MID;

    typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} step_t;

    step_t                 state [3];
    logic [CW-1:0]         cnt   [3];
    logic signed [DW-1:0]  samp  [3];
    logic [CW-1:0]         hold  [3];
    logic [SCW-1:0]        sc;

    function automatic step_t next_step(step_t s);
        return step_t'(s + 3'd1);
    endfunction

    function automatic logic signed [DW-1:0] level(step_t s);
        case (s)
            S0:      return '0;
            S1:      return LV_MID;
            S2:      return LV_HI;
            S3:      return LV_MID;
            S4:      return '0;
            S5:      return LV_NMID;
            S6:      return LV_LO;
            default: return LV_NMID;
        endcase
    endfunction

    // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
    always_comb begin
        hold[0] = hold0;
        hold[1] = hold1;
        hold[2] = hold2;
    end

    // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                state[k] <= S0;
                cnt[k]   <= '0;
                samp[k]  <= '0;
            end
            sc        <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            tone_idx  <= 2'd0;
        end else if (en) begin
            // A hold lowered below the running count advances at once rather than wrapping.
            for (int k = 0; k < 3; k++) begin
                if (cnt[k] < hold[k]) begin
                    cnt[k] <= cnt[k] + CW'(1);
                end else begin
                    cnt[k]   <= '0;
                    state[k] <= next_step(state[k]);
                    samp[k]  <= level(next_step(state[k]));
                end
            end

            if (sc < lead_in) begin
                sc       <= sc + SCW'(1);
                out      <= '0;
                tone_idx <= 2'd0;
            end else if (sc < seg_end0) begin
                sc        <= sc + SCW'(1);
                out       <= samp[0];
                tone_idx  <= 2'd0;
                out_valid <= 1'b1;
            end else if (sc < seg_end1) begin
                sc        <= sc + SCW'(1);
                out       <= samp[1];
                tone_idx  <= 2'd1;
                out_valid <= 1'b1;
            end else begin
                out       <= samp[2];
                tone_idx  <= 2'd2;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rsp_tone_stepper.sv
// Bench for rsp_tone_stepper: closed-form model of the tone/segment schedule checked every
// cycle, plus hand-computed checks at the boundary edges.
module tb_rsp_tone_stepper;

    localparam int DW  = 16;
    localparam int CW  = 6;
    localparam int SCW = 13;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 en = 1'b0;
    logic [CW-1:0]        hold0 = '0, hold1 = '0, hold2 = '0;
    logic [SCW-1:0]       lead_in = '0, seg_end0 = '0, seg_end1 = '0;
    logic signed [DW-1:0] out;
    logic                 out_valid;
    logic [1:0]           tone_idx;

    int  tests = 0;
    int  fails = 0;
    int  n = 0;          // enabled edges since the last reset edge
    bit  model_on = 1'b0;

    rsp_tone_stepper dut (
        .clk(clk), .reset(reset), .en(en),
        .hold0(hold0), .hold1(hold1), .hold2(hold2),
        .lead_in(lead_in), .seg_end0(seg_end0), .seg_end1(seg_end1),
        .out(out), .out_valid(out_valid), .tone_idx(tone_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lvl(int s);
        case (s % 8)
            0: return 0;
            1: return 23170;
            2: return 32767;
            3: return 23170;
            4: return 0;
            5: return -23170;
            6: return -32768;
            default: return -23170;
        endcase
    endfunction

    // Sample of a generator after m enabled edges with a constant hold h.
    function automatic int tone(int h, int m);
        return lvl((m / (h + 1)) % 8);
    endfunction

    always @(posedge clk) begin
        if (reset) n <= 0;
        else if (en) n <= n + 1;
    end

    always @(negedge clk) begin
        int m, top, s, e_out, e_val, e_idx;
        if (model_on) begin
            e_out = 0; e_val = 0; e_idx = 0;
            if (n > 0) begin
                m   = n - 1;
                top = int'(lead_in);
                if (int'(seg_end0) > top) top = int'(seg_end0);
                if (int'(seg_end1) > top) top = int'(seg_end1);
                s = (m < top) ? m : top;
                if (s < int'(lead_in)) begin
                    e_out = 0; e_val = 0; e_idx = 0;
                end else if (s < int'(seg_end0)) begin
                    e_out = tone(int'(hold0), m); e_val = 1; e_idx = 0;
                end else if (s < int'(seg_end1)) begin
                    e_out = tone(int'(hold1), m); e_val = 1; e_idx = 1;
                end else begin
                    e_out = tone(int'(hold2), m); e_val = 1; e_idx = 2;
                end
            end
            check("model_out", out, e_out);
            check("model_valid", out_valid, e_val);
            check("model_idx", tone_idx, e_idx);
        end
    end

    task automatic step(int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        // Main configuration
        hold0 = 6'd30; hold1 = 6'd15; hold2 = 6'd0;
        lead_in = 13'd15; seg_end0 = 13'd610; seg_end1 = 13'd1150;
        en = 1'b1; reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        model_on = 1'b1;

        step(15);
        check("lead_out_e15", out, 0);
        check("lead_valid_e15", out_valid, 0);
        step(1);
        check("valid_e16", out_valid, 1);
        check("t0_out_e16", out, 0);
        step(16);
        check("t0_mid_e32", out, 23170);
        step(31);
        check("t0_hi_e63", out, 32767);
        step(547);
        check("idx0_e610", tone_idx, 0);
        step(1);
        check("idx1_e611", tone_idx, 1);
        check("t1_out_e611", out, -32768);

        // Freeze mid tone 1
        step(89);
        #1 en = 1'b0;
        step(5);
        check("freeze_out", out, 23170);
        check("freeze_idx", tone_idx, 1);
        step(5);
        #1 en = 1'b1;
        step(4);
        check("resume_out_n704", out, 23170);
        step(1);
        check("resume_out_n705", out, 0);

        step(446);
        check("idx2_n1151", tone_idx, 2);
        check("t2_out_n1151", out, -32768);
        step(1);
        check("t2_out_n1152", out, -23170);
        step(20);

        // One-cycle reset mid tone 2
        #1 reset = 1'b1;
        step(1);
        check("rst_out", out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_idx", tone_idx, 0);
        #1 reset = 1'b0;
        step(15);
        check("relead_valid_e15", out_valid, 0);
        step(1);
        check("relead_valid_e16", out_valid, 1);
        step(10);

        // All boundaries at 5: tone 0 and tone 1 skipped
        model_on = 1'b0;
        #1 lead_in = 13'd5; seg_end0 = 13'd5; seg_end1 = 13'd5; reset = 1'b1;
        step(2);
        #1 reset = 1'b0;
        model_on = 1'b1;
        step(5);
        check("deg5_valid_e5", out_valid, 0);
        step(1);
        check("deg5_valid_e6", out_valid, 1);
        check("deg5_idx_e6", tone_idx, 2);
        check("deg5_out_e6", out, -23170);
        step(10);

        // All boundaries zero: tone 2 on the first edge
        model_on = 1'b0;
        #1 lead_in = 13'd0; seg_end0 = 13'd0; seg_end1 = 13'd0; reset = 1'b1;
        step(2);
        #1 reset = 1'b0;
        model_on = 1'b1;
        step(1);
        check("deg0_valid_e1", out_valid, 1);
        check("deg0_idx_e1", tone_idx, 2);
        check("deg0_out_e1", out, 0);
        step(1);
        check("deg0_out_e2", out, 23170);
        step(8);

        // Live hold drop below the running count on tone 0
        model_on = 1'b0;
        #1 lead_in = 13'd0; seg_end0 = 13'd100; seg_end1 = 13'd200; hold0 = 6'd30; reset = 1'b1;
        step(2);
        #1 reset = 1'b0;
        step(20);
        #1 hold0 = 6'd3;
        step(1);
        check("hdrop_out_e21", out, 0);
        step(1);
        check("hdrop_out_e22", out, 23170);
        step(3);
        check("hdrop_out_e25", out, 23170);
        step(1);
        check("hdrop_out_e26", out, 32767);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
